// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with occupancy flags, overflow/underflow pulses and a
// selectable read mode: registered read (FWFT=0) or first-word-fall-through.
module param_sync_fifo #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2,
  parameter int unsigned FWFT     = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       data_in,
  input  logic                   w_en,
  input  logic                   r_en,
  output logic [WIDTH-1:0]       data_out,
  output logic                   empty,
  output logic                   full,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] fifo_cnt,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             rd_acc;
  logic             wr_acc;
  logic [CW-1:0]    cnt_next;

  // A write into a full FIFO is still accepted when a read frees a slot on the same edge.
  always_comb begin
    rd_acc   = r_en && !empty;
    wr_acc   = w_en && (!full || rd_acc);
    cnt_next = fifo_cnt + CW'(wr_acc) - CW'(rd_acc);
  end

  // Pointers, count, flags and error pulses; flags are registered from the next count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_cnt     <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      fifo_cnt     <= cnt_next;
      empty        <= (cnt_next == '0);
      full         <= (cnt_next == CW'(DEPTH));
      almost_full  <= (cnt_next >= CW'(AF_LEVEL));
      almost_empty <= (cnt_next <= CW'(AE_LEVEL));
      overflow     <= w_en && !wr_acc;
      underflow    <= r_en && !rd_acc;
    end
  end

  // Storage is deliberately not reset; stale entries are unreachable after reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem[wr_ptr] <= data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head entry is presented directly; zero is shown while empty.
      always_comb begin
        data_out = empty ? '0 : mem[rd_ptr];
      end
    end else begin : g_std
      always_ff @(posedge clk) begin
        if (rst)         data_out <= '0;
        else if (rd_acc) data_out <= mem[rd_ptr];
      end
    end
  endgenerate

endmodule

// File: tb/tb_param_sync_fifo.sv
// Randomized and directed bench for param_sync_fifo; a registered-read and a
// FWFT instance share stimulus and are checked against one queue model.
module tb_param_sync_fifo;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AF    = 6;
  localparam int unsigned AE    = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] data_in;
  logic             w_en;
  logic             r_en;

  logic [WIDTH-1:0] dout [2];
  logic             emp  [2];
  logic             ful  [2];
  logic             af   [2];
  logic             ae   [2];
  logic [3:0]       cnt  [2];
  logic             ovf  [2];
  logic             udf  [2];

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] exp_d0;
  logic             exp_ovf;
  logic             exp_udf;

  always #5 clk = ~clk;

  param_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .data_in(data_in), .w_en(w_en), .r_en(r_en),
    .data_out(dout[0]), .empty(emp[0]), .full(ful[0]), .almost_full(af[0]),
    .almost_empty(ae[0]), .fifo_cnt(cnt[0]), .overflow(ovf[0]), .underflow(udf[0])
  );

  param_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .data_in(data_in), .w_en(w_en), .r_en(r_en),
    .data_out(dout[1]), .empty(emp[1]), .full(ful[1]), .almost_full(af[1]),
    .almost_empty(ae[1]), .fifo_cnt(cnt[1]), .overflow(ovf[1]), .underflow(udf[1])
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected behaviour after one edge, from the queue occupancy rules.
  task automatic model_edge(input logic r, input logic w, input logic rd, input logic [WIDTH-1:0] d);
    bit rd_ok, wr_ok;
    if (r) begin
      q.delete();
      exp_d0  = '0;
      exp_ovf = 1'b0;
      exp_udf = 1'b0;
    end else begin
      rd_ok = rd && (q.size() > 0);
      wr_ok = w && ((q.size() < DEPTH) || rd_ok);
      if (rd_ok) exp_d0 = q.pop_front();
      if (wr_ok) q.push_back(d);
      exp_ovf = w && !wr_ok;
      exp_udf = rd && !rd_ok;
    end
  endtask

  task automatic check_all();
    int unsigned sz;
    sz = q.size();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("f%0d.cnt", i),   cnt[i], sz);
      check($sformatf("f%0d.empty", i), emp[i], (sz == 0) ? 1 : 0);
      check($sformatf("f%0d.full", i),  ful[i], (sz == DEPTH) ? 1 : 0);
      check($sformatf("f%0d.af", i),    af[i],  (sz >= AF) ? 1 : 0);
      check($sformatf("f%0d.ae", i),    ae[i],  (sz <= AE) ? 1 : 0);
      check($sformatf("f%0d.ovf", i),   ovf[i], exp_ovf);
      check($sformatf("f%0d.udf", i),   udf[i], exp_udf);
    end
    check("f0.dout", dout[0], exp_d0);
    if (sz > 0) check("f1.dout", dout[1], q[0]);
  endtask

  task automatic step(input logic r, input logic w, input logic rd, input logic [WIDTH-1:0] d);
    rst = r; w_en = w; r_en = rd; data_in = d;
    @(posedge clk);
    model_edge(r, w, rd, d);
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1; w_en = 1'b0; r_en = 1'b0; data_in = '0;
    exp_d0 = '0; exp_ovf = 1'b0; exp_udf = 1'b0;

    // Reset state
    step(1, 0, 0, 8'h00);
    check("rst.empty", emp[0], 1);
    check("rst.ae", ae[0], 1);
    step(0, 0, 0, 8'h00);

    // Fill, then a rejected write
    for (int i = 1; i <= 8; i++) begin
      step(0, 1, 0, 8'(i));
      if (i == 5) check("fill5.af", af[0], 0);
      if (i == 6) check("fill6.af", af[0], 1);
    end
    check("fill.full", ful[0], 1);
    step(0, 1, 0, 8'hFF);
    check("ovf.pulse", ovf[0], 1);
    check("ovf.cnt", cnt[0], 8);
    step(0, 0, 0, 8'h00);
    check("ovf.clear", ovf[0], 0);

    // Drain in order, then a rejected read
    for (int i = 1; i <= 8; i++) begin
      step(0, 0, 1, 8'h00);
      check("drain.dout", dout[0], i);
    end
    step(0, 0, 1, 8'h00);
    check("udf.pulse", udf[0], 1);
    check("udf.hold", dout[0], 8'h08);

    // Simultaneous read/write while full, wrapping pointers
    for (int i = 1; i <= 8; i++) step(0, 1, 0, 8'(i));
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 1, 8'(8'hA0 + i));
      check("rw.full", ful[0], 1);
    end
    for (int i = 0; i < 8; i++) step(0, 0, 1, 8'h00);
    check("wrap.last", dout[0], 8'hA3);

    // Simultaneous read/write while empty
    step(0, 1, 1, 8'h55);
    check("e_rw.udf", udf[0], 1);
    check("e_rw.cnt", cnt[0], 1);
    step(0, 0, 0, 8'h00);
    check("e_rw.fwft", dout[1], 8'h55);
    step(0, 0, 1, 8'h00);

    // Reset mid-operation with a pending write
    for (int i = 0; i < 5; i++) step(0, 1, 0, 8'(8'h30 + i));
    step(1, 1, 0, 8'hEE);
    check("mid_rst.cnt", cnt[0], 0);
    check("mid_rst.dout", dout[0], 0);
    check("mid_rst.ovf", ovf[0], 0);

    // Random traffic with load phases biased toward full, empty and balanced
    for (int c = 0; c < 10000; c++) begin
      int unsigned wp;
      logic r, w, rd;
      case ((c / 300) % 3)
        0:       wp = 75;
        1:       wp = 25;
        default: wp = 50;
      endcase
      r  = ($urandom_range(0, 999) == 0);
      w  = ($urandom_range(0, 99) < wp);
      rd = ($urandom_range(0, 99) < (100 - wp));
      step(r, w, rd, 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
